// File: rtl/ftdi_fifo_arbiter.sv
// Two-client arbiter for the FT2232H byte channel: client 0 high priority, client 1 starvation-protected.
// Latency: start pulse one cycle after the grant edge; done one cycle after completion or TIMEOUT_CYCLES+1 after start.
// Backpressure: no grant while fifo_busy_i is high; a timed-out op parks in RECOVER until the FIFO layer is idle.
module ftdi_fifo_arbiter #(
    parameter int TIMEOUT_CYCLES = 1200,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] wr_i,
    input  logic [7:0] wdata0_i,
    input  logic [7:0] wdata1_i,
    output logic [1:0] done_o,
    output logic       err_o,
    output logic       timeout_o,
    output logic [7:0] rdata_o,
    output logic       owner_o,
    output logic       fifo_tx_data_rdy_o,
    output logic [7:0] fifo_tx_data_o,
    output logic       fifo_rx_poll_o,
    input  logic       fifo_tx_ok_i,
    input  logic       fifo_tx_err_i,
    input  logic       fifo_rx_data_rdy_i,
    input  logic       fifo_rx_err_i,
    input  logic [7:0] fifo_rx_data_i,
    input  logic       fifo_busy_i
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DONE    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_tcnt;
    logic [SW-1:0] r_starve;
    logic          r_wr;
    logic          r_owner;
    logic [1:0]    r_done;
    logic          r_err;
    logic          r_timeout;
    logic [7:0]    r_rdata;
    logic          r_tx_rdy;
    logic [7:0]    r_tx_data;
    logic          r_rx_poll;

    logic          w_grant_vld;
    logic          w_grant_sel;
    logic          w_grant_wr;
    logic [7:0]    w_grant_byte;
    logic          w_cpl_ok;
    logic          w_cpl_err;
    logic          w_expire;
    logic [1:0]    w_owner_oh;

    // Client 1 wins a contested grant only once client 0 has used up its allowance.
    assign w_grant_vld  = (r_state == S_IDLE) && !fifo_busy_i && (req_i != 2'b00);
    assign w_grant_sel  = req_i[1] && (!req_i[0] || (r_starve == STARVE_MAX));
    assign w_grant_wr   = w_grant_sel ? wr_i[1] : wr_i[0];
    assign w_grant_byte = w_grant_sel ? wdata1_i : wdata0_i;

    assign w_cpl_ok   = r_wr ? fifo_tx_ok_i  : fifo_rx_data_rdy_i;
    assign w_cpl_err  = r_wr ? fifo_tx_err_i : fifo_rx_err_i;
    assign w_expire   = (r_tcnt == TMO_LAST);
    assign w_owner_oh = r_owner ? 2'b10 : 2'b01;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state   <= S_IDLE;
            r_tcnt    <= '0;
            r_starve  <= '0;
            r_wr      <= 1'b0;
            r_owner   <= 1'b0;
            r_done    <= 2'b00;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_rdata   <= 8'h00;
            r_tx_rdy  <= 1'b0;
            r_tx_data <= 8'h00;
            r_rx_poll <= 1'b0;
        end else begin
            r_done    <= 2'b00;
            r_err     <= 1'b0;
            r_timeout <= 1'b0;
            r_tx_rdy  <= 1'b0;
            r_rx_poll <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_owner <= w_grant_sel;
                        r_wr    <= w_grant_wr;
                        r_tcnt  <= '0;
                        if (w_grant_wr) begin
                            r_tx_rdy  <= 1'b1;
                            r_tx_data <= w_grant_byte;
                        end else begin
                            r_rx_poll <= 1'b1;
                        end
                        if (!w_grant_sel && req_i[1]) begin
                            if (r_starve != STARVE_MAX)
                                r_starve <= r_starve + 1'b1;
                        end else begin
                            r_starve <= '0;
                        end
                        r_state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // A completion on the expiry cycle still counts as a normal completion.
                    if (w_cpl_ok || w_cpl_err) begin
                        r_done <= w_owner_oh;
                        r_err  <= w_cpl_err;
                        if (!r_wr && !w_cpl_err)
                            r_rdata <= fifo_rx_data_i;
                        r_state <= S_DONE;
                    end else if (w_expire) begin
                        r_done    <= w_owner_oh;
                        r_err     <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_RECOVER;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                S_RECOVER: begin
                    if (!fifo_busy_i)
                        r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign done_o             = r_done;
    assign err_o              = r_err;
    assign timeout_o          = r_timeout;
    assign rdata_o            = r_rdata;
    assign owner_o            = r_owner;
    assign fifo_tx_data_rdy_o = r_tx_rdy;
    assign fifo_tx_data_o     = r_tx_data;
    assign fifo_rx_poll_o     = r_rx_poll;

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// Directed bench for ftdi_fifo_arbiter: per-cycle vector table plus starvation, timeout and reset sequences.
module tb_ftdi_fifo_arbiter;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [1:0] req_i;
    logic [1:0] wr_i;
    logic [7:0] wdata0_i;
    logic [7:0] wdata1_i;
    logic [1:0] done_o;
    logic       err_o;
    logic       timeout_o;
    logic [7:0] rdata_o;
    logic       owner_o;
    logic       fifo_tx_data_rdy_o;
    logic [7:0] fifo_tx_data_o;
    logic       fifo_rx_poll_o;
    logic       fifo_tx_ok_i;
    logic       fifo_tx_err_i;
    logic       fifo_rx_data_rdy_i;
    logic       fifo_rx_err_i;
    logic [7:0] fifo_rx_data_i;
    logic       fifo_busy_i;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    ftdi_fifo_arbiter #(
        .TIMEOUT_CYCLES(8),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk_i             (clk_i),
        .reset_ni          (reset_ni),
        .req_i             (req_i),
        .wr_i              (wr_i),
        .wdata0_i          (wdata0_i),
        .wdata1_i          (wdata1_i),
        .done_o            (done_o),
        .err_o             (err_o),
        .timeout_o         (timeout_o),
        .rdata_o           (rdata_o),
        .owner_o           (owner_o),
        .fifo_tx_data_rdy_o(fifo_tx_data_rdy_o),
        .fifo_tx_data_o    (fifo_tx_data_o),
        .fifo_rx_poll_o    (fifo_rx_poll_o),
        .fifo_tx_ok_i      (fifo_tx_ok_i),
        .fifo_tx_err_i     (fifo_tx_err_i),
        .fifo_rx_data_rdy_i(fifo_rx_data_rdy_i),
        .fifo_rx_err_i     (fifo_rx_err_i),
        .fifo_rx_data_i    (fifo_rx_data_i),
        .fifo_busy_i       (fifo_busy_i)
    );

    // {done, err, timeout, rdata, owner, tx_rdy, tx_data, rx_poll}
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [7:0]  wd0;
        logic [7:0]  wd1;
        logic [3:0]  cpl;
        logic [7:0]  rxd;
        logic        busy;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   starve_exp [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    function automatic logic [22:0] outs();
        return {done_o, err_o, timeout_o, rdata_o, owner_o,
                fifo_tx_data_rdy_o, fifo_tx_data_o, fifo_rx_poll_o};
    endfunction

    function automatic logic [22:0] ex(logic [1:0] d, logic e, logic t, logic [7:0] rd,
                                       logic ow, logic tr, logic [7:0] td, logic rp);
        return {d, e, t, rd, ow, tr, td, rp};
    endfunction

    function automatic vec_t mk(logic [1:0] req, logic [1:0] wr, logic [7:0] wd0,
                                logic [7:0] wd1, logic [3:0] cpl, logic [7:0] rxd,
                                logic busy, logic [22:0] e);
        vec_t v;
        v.req = req; v.wr = wr; v.wd0 = wd0; v.wd1 = wd1;
        v.cpl = cpl; v.rxd = rxd; v.busy = busy; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] wr, input logic [7:0] wd0,
                         input logic [7:0] wd1, input logic [3:0] cpl, input logic [7:0] rxd,
                         input logic busy);
        req_i = req; wr_i = wr; wdata0_i = wd0; wdata1_i = wd1;
        {fifo_tx_ok_i, fifo_tx_err_i, fifo_rx_data_rdy_i, fifo_rx_err_i} = cpl;
        fifo_rx_data_i = rxd; fifo_busy_i = busy;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_got;
        int got [10];
        int done_cyc;
        int n_done;
        int n_start;
        bit seen;

        reset_ni = 1'b1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0);
        #1 reset_ni = 1'b0;
        repeat (2) step();
        chk("reset_outputs", 32'(outs()), 32'h0);
        #2 reset_ni = 1'b1;

        // Client 0 TX 0xA5, completion five cycles after the start pulse.
        vecs.push_back(mk(2'b01, 2'b01, 8'hA5, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h00,0,1,8'hA5,0)));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h00,0,0,8'hA5,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b1000, 8'h00, 1'b0, ex(2'b01,0,0,8'h00,0,0,8'hA5,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h00,0,0,8'hA5,0)));
        // Client 1 RX 0x3C with a spurious TX ok in WAIT.
        vecs.push_back(mk(2'b10, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h00,1,0,8'hA5,1)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b1000, 8'h00, 1'b0, ex(2'b00,0,0,8'h00,1,0,8'hA5,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0010, 8'h3C, 1'b0, ex(2'b10,0,0,8'h3C,1,0,8'hA5,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,1,0,8'hA5,0)));
        // TX ok and TX err together: error wins.
        vecs.push_back(mk(2'b01, 2'b01, 8'h11, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,1,8'h11,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b1100, 8'h00, 1'b0, ex(2'b01,1,0,8'h3C,0,0,8'h11,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,0,8'h11,0)));
        // Completion on the expiry cycle beats the timeout.
        vecs.push_back(mk(2'b01, 2'b01, 8'h22, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,1,8'h22,0)));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,0,8'h22,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b1000, 8'h00, 1'b0, ex(2'b01,0,0,8'h3C,0,0,8'h22,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,0,8'h22,0)));
        // Busy blocks grant; RX ignores TX err; RX err leaves rdata alone.
        vecs.push_back(mk(2'b01, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b1, ex(2'b00,0,0,8'h3C,0,0,8'h22,0)));
        vecs.push_back(mk(2'b01, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,0,8'h22,1)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0100, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,0,8'h22,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0001, 8'h55, 1'b0, ex(2'b01,1,0,8'h3C,0,0,8'h22,0)));
        vecs.push_back(mk(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0, ex(2'b00,0,0,8'h3C,0,0,8'h22,0)));

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].wr, vecs[i].wd0, vecs[i].wd1, vecs[i].cpl, vecs[i].rxd, vecs[i].busy);
            step();
            chk($sformatf("vec[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Both clients requesting continuously, immediate TX completion.
        drive(2'b11, 2'b11, 8'h0A, 8'h1B, 4'b1000, 8'h00, 1'b0);
        n_got = 0;
        for (int c = 0; c < 60 && n_got < 10; c++) begin
            step();
            if (done_o != 2'b00) begin
                got[n_got] = done_o[1] ? 1 : 0;
                n_got++;
                if (n_got == 10)
                    drive(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0);
            end
        end
        chk("starve_grants_seen", 32'(n_got), 32'd10);
        for (int i = 0; i < n_got; i++)
            chk($sformatf("starve_order[%0d]", i), 32'(got[i]), 32'(starve_exp[i]));
        drive(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0);
        step();

        // Timeout with the FIFO layer stuck busy, then a late completion in RECOVER.
        drive(2'b01, 2'b01, 8'h77, 8'h00, 4'b0000, 8'h00, 1'b0);
        step();
        chk("tmo_start_pulse", 32'({fifo_tx_data_rdy_o, fifo_tx_data_o}), 32'h177);
        fifo_busy_i = 1'b1;
        done_cyc = -1; n_done = 0; n_start = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            fifo_tx_ok_i = 1'b0;
            if (fifo_tx_data_rdy_o || fifo_rx_poll_o) n_start++;
            if (done_o != 2'b00) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    chk("tmo_flags", 32'({done_o, err_o, timeout_o}), 32'b0111);
                    fifo_tx_ok_i = 1'b1;
                end
            end
        end
        chk("tmo_done_cycle", 32'(done_cyc), 32'd9);
        chk("tmo_single_done", 32'(n_done), 32'd1);
        chk("tmo_no_grant_busy", 32'(n_start), 32'd0);
        fifo_busy_i = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            step();
            if (fifo_tx_data_rdy_o) seen = 1'b1;
        end
        chk("tmo_regrant_after_busy", 32'(seen), 32'd1);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 4'b1000, 8'h00, 1'b0);
        step();
        chk("tmo_followup_done", 32'({done_o, err_o, timeout_o}), 32'b0100);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0);
        step();

        // Asynchronous reset in WAIT.
        drive(2'b10, 2'b10, 8'h00, 8'hC3, 4'b0000, 8'h00, 1'b0);
        step();
        chk("rst_start_pulse", 32'({owner_o, fifo_tx_data_rdy_o, fifo_tx_data_o}), 32'h3C3);
        drive(2'b00, 2'b00, 8'h00, 8'h00, 4'b0000, 8'h00, 1'b0);
        step();
        #2 reset_ni = 1'b0;
        #1 chk("rst_async_outputs", 32'(outs()), 32'h0);
        step();
        #2 reset_ni = 1'b1;
        fifo_tx_ok_i = 1'b1;
        n_done = 0; n_start = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (done_o != 2'b00) n_done++;
            if (fifo_tx_data_rdy_o || fifo_rx_poll_o) n_start++;
        end
        chk("rst_no_done", 32'(n_done), 32'd0);
        chk("rst_no_start", 32'(n_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ftdi_fifo_arbiter.md
# ftdi_fifo_arbiter

Shares the single FT2232H byte-channel (the `fifo_interface` TX/RX command ports) between two requesters: client 0 (audio sample stream, high priority) and client 1 (control/status channel, low priority). It serialises byte-level TX and RX operations and guarantees client 1 is never starved. A watchdog aborts operations the FIFO layer never completes. It sits between the requesters and `fifo_interface`, replacing direct per-client drive of `tx_data_rdy`/`rx_poll`.

## Interface
- `TIMEOUT_CYCLES`, 1200: max WAIT cycles before an op is aborted (100 µs at 12 MHz); ≥2.
- `STARVE_LIMIT`, 4: consecutive client-0 grants allowed while client 1 is requesting; ≥1.
- `clk_i`  in  1  system clock.
- `reset_ni`  in  1  **reset, asynchronous, active-low**.
- `req_i`  in  2  per-client request level; bit n = client n.
- `wr_i`  in  2  per-client op type: 1 = TX byte, 0 = RX byte; sampled at grant.
- `wdata0_i`, `wdata1_i`  in  8 each  TX byte per client; sampled at grant.
- `done_o`  out  2  one-cycle completion pulse to the owning client.
- `err_o`  out  1  valid with `done_o`: 1 = op failed (FIFO error or timeout).
- `timeout_o`  out  1  one-cycle pulse coincident with a timeout `done_o`.
- `rdata_o`  out  8  received byte; valid with `done_o` of a successful RX.
- `owner_o`  out  1  client owning the channel while not IDLE.
- `fifo_tx_data_rdy_o`  out  1  one-cycle TX start pulse.
- `fifo_tx_data_o`  out  8  TX byte, held from issue until next issue.
- `fifo_rx_poll_o`  out  1  one-cycle RX start pulse.
- `fifo_tx_ok_i`, `fifo_tx_err_i`  in  1 each  TX completion (success / failure) pulses.
- `fifo_rx_data_rdy_i`, `fifo_rx_err_i`  in  1 each  RX completion (success / failure) pulses.
- `fifo_rx_data_i`  in  8  received byte, valid with `fifo_rx_data_rdy_i`.
- `fifo_busy_i`  in  1  FIFO layer busy.

## Operation
- States: IDLE, WAIT, DONE, RECOVER. Reset → IDLE; all outputs 0, starvation counter 0, timeout counter 0.
- IDLE: if `fifo_busy_i`=0 and `req_i`≠0, grant:
  - only one requesting → that client.
  - both requesting → client 1 if starve count == `STARVE_LIMIT`, else client 0.
  - On grant: latch op type and byte, set `owner_o`, pulse `fifo_tx_data_rdy_o` (TX, with `fifo_tx_data_o` = latched byte) or `fifo_rx_poll_o` (RX) for one cycle, clear timeout counter → WAIT.
  - Starve count: +1 (saturating at `STARVE_LIMIT`) when client 0 is granted with `req_i[1]`=1; cleared when client 1 is granted or when client 0 is granted with `req_i[1]`=0.
  - `fifo_busy_i`=1 → no grant, stay IDLE.
- WAIT: only the completion pair matching the latched op type is honoured; the other pair is ignored.
  - Success pulse → DONE with err 0; for RX, capture `fifo_rx_data_i` into `rdata_o`.
  - Error pulse → DONE with err 1. Success and error in the same cycle → error wins.
  - Timeout counter increments each WAIT cycle. No completion within `TIMEOUT_CYCLES` WAIT cycles → RECOVER with err 1 and timeout flagged. Completion and expiry in the same cycle → completion wins.
- DONE (exactly 1 cycle): `done_o[owner]`=1, `err_o` = result, `timeout_o` = 0 → IDLE.
- RECOVER: on entry cycle pulse `done_o[owner]`, `err_o`=1, `timeout_o`=1. Stay until `fifo_busy_i`=0 → IDLE. Late completion pulses arriving here are discarded.
- `rdata_o` holds its last value otherwise. `err_o` and `timeout_o` are 0 whenever `done_o`=0.
- Requests are levels. The arbiter never samples `req_i` in DONE or RECOVER. A client still requesting in the IDLE cycle after its `done_o` starts a new op.
- A client dropping `req_i` after grant does not cancel the op; `done_o` is still delivered.

## Timing
- All outputs registered. Grant → start pulse is visible in the cycle after the IDLE decision edge.
- Minimum op: IDLE(1) + WAIT(≥1) + DONE(1). Back-to-back ops from one client take ≥3 cycles per byte.
- Completion pulse in WAIT cycle k → `done_o` high in cycle k+1.
- Timeout: `done_o`/`timeout_o` is asserted `TIMEOUT_CYCLES`+1 cycles after the start pulse.
- Asynchronous reset mid-op: immediately IDLE, all outputs 0, no `done_o` is ever issued for the aborted op.

## Test plan
- Client 0 TX 0xA5 alone → `fifo_tx_data_rdy_o` pulse with `fifo_tx_data_o`=0xA5; `fifo_tx_ok_i` 5 cycles later → `done_o`=01, `err_o`=0 next cycle.
- Client 1 RX; `fifo_rx_data_rdy_i` with 0x3C → `done_o`=10, `rdata_o`=0x3C, `err_o`=0. A spurious `fifo_tx_ok_i` during WAIT is ignored.
- Both clients hold `req_i`=11 continuously (TX, immediate `fifo_tx_ok_i`) → grant order 0,0,0,0,1,0,0,0,0,1 with `STARVE_LIMIT`=4.
- `TIMEOUT_CYCLES`=8, no completion, `fifo_busy_i` high for 20 cycles → `done_o` with `err_o`=1 and `timeout_o`=1 9 cycles after issue. No new grant until `fifo_busy_i` falls. A late `fifo_tx_ok_i` in RECOVER causes no second `done_o`.
- `fifo_tx_ok_i` and `fifo_tx_err_i` in the same cycle → `err_o`=1. Completion on the expiry cycle → `err_o`=0, `timeout_o`=0.
- Assert `reset_ni`=0 during WAIT → outputs 0 asynchronously. After release, with `req_i`=00, no `done_o` and no start pulse.
